// File: rtl/video_timing_gen.sv
// Raster timing and RGB888 pixel stream for a DVI/HDMI transmitter.
// A free-running h/v counter feeds a three-register pipeline:
//   stage 1 issues the pixel request (data_req, xpos, ypos),
//   stage 2 waits for the upstream pixel to arrive,
//   stage 3 registers sync, data enable and the selected pixel.
// Every output of stage 3 is therefore aligned to the same raster position.
module video_timing_gen #(
  parameter int   H_SYNC   = 40,
  parameter int   H_BACK   = 220,
  parameter int   H_DISP   = 1280,
  parameter int   H_FRONT  = 110,
  parameter int   V_SYNC   = 5,
  parameter int   V_BACK   = 20,
  parameter int   V_DISP   = 720,
  parameter int   V_FRONT  = 5,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] pixel_data,
  output logic        data_req,
  output logic [11:0] pixel_xpos,
  output logic [11:0] pixel_ypos,
  output logic        video_hsync,
  output logic        video_vsync,
  output logic        video_de,
  output logic [23:0] video_din,
  output logic        frame_start
);

  localparam logic [11:0] H_LAST  = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [11:0] V_LAST  = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [11:0] H_SYNCW = 12'(H_SYNC);
  localparam logic [11:0] V_SYNCW = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_S = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_E = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] V_ACT_S = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT_E = 12'(V_SYNC + V_BACK + V_DISP);
  // Narrow displays (<8 pixels) would give a zero bar width; clamp to 1.
  localparam logic [11:0] BAR_W   = 12'((H_DISP / 8 > 0) ? H_DISP / 8 : 1);

  localparam logic [1:0] PAT_EXT  = 2'b00;
  localparam logic [1:0] PAT_BAR  = 2'b01;
  localparam logic [1:0] PAT_GRID = 2'b10;
  localparam logic [1:0] PAT_RED  = 2'b11;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } stage_t;

  localparam stage_t STG_RST = '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL,
                                 fs: 1'b0, x: 12'd0, y: 12'd0};

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [1:0]  pat_q;
  stage_t      s1_q, s1_d, s2_q;
  logic        de_q, hs_q, vs_q, fs_q;
  logic [23:0] din_q, din_d;
  logic [23:0] pix;
  logic [11:0] bar_idx;
  logic [2:0]  bar;
  logic        h_act, v_act;

  // Next raster position: h wraps at end of line, v advances on h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 12'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  // Raster counters.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Pattern latches only at the frame origin so a frame is never torn.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n)                               pat_q <= PAT_EXT;
    else if (h_cnt_q == 12'd0 && v_cnt_q == 12'd0) pat_q <= pattern_sel;
  end

  // Stage-1 decode of the current raster position.
  always_comb begin
    h_act   = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
    v_act   = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
    s1_d    = STG_RST;
    s1_d.de = h_act && v_act;
    s1_d.hs = (h_cnt_q < H_SYNCW) ? SYNC_POL : ~SYNC_POL;
    s1_d.vs = (v_cnt_q < V_SYNCW) ? SYNC_POL : ~SYNC_POL;
    s1_d.fs = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    s1_d.x  = s1_d.de ? h_cnt_q - H_ACT_S : 12'd0;
    s1_d.y  = s1_d.de ? v_cnt_q - V_ACT_S : 12'd0;
  end

  // Stage 1 (request) and stage 2 (wait for upstream pixel).
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= STG_RST;
      s2_q <= STG_RST;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
    end
  end

  // Pixel source for the stage-2 position; blanking forces black.
  always_comb begin
    bar_idx = s2_q.x / BAR_W;
    bar     = (bar_idx > 12'd7) ? 3'd7 : bar_idx[2:0];
    pix     = 24'h000000;
    case (pat_q)
      PAT_EXT:  pix = pixel_data;
      PAT_BAR: begin
        case (bar)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFFFF00;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      PAT_GRID: pix = (s2_q.x[4:0] == 5'd0 || s2_q.y[4:0] == 5'd0) ? 24'hFFFFFF : 24'h000000;
      default:  pix = 24'hFF0000;
    endcase
    din_d = s2_q.de ? pix : 24'h000000;
  end

  // Stage 3: registered transmitter-facing outputs.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      fs_q  <= 1'b0;
      din_q <= 24'h000000;
    end else begin
      de_q  <= s2_q.de;
      hs_q  <= s2_q.hs;
      vs_q  <= s2_q.vs;
      fs_q  <= s2_q.fs;
      din_q <= din_d;
    end
  end

  assign data_req    = s1_q.de;
  assign pixel_xpos  = s1_q.x;
  assign pixel_ypos  = s1_q.y;
  assign video_de    = de_q;
  assign video_hsync = hs_q;
  assign video_vsync = vs_q;
  assign frame_start = fs_q;
  assign video_din   = din_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 15x8 raster (H 2/3/8/2, V 1/2/4/1).
// Two instances share the inputs: one with active-high sync, one active-low.
module tb_video_timing_gen;

  localparam int H_TOT = 15;
  localparam int V_TOT = 8;
  localparam int FRAME = H_TOT * V_TOT;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic [1:0]  pattern_sel;
  logic [23:0] pixel_data;

  logic        req_a, hs_a, vs_a, de_a, fs_a;
  logic [11:0] xpos_a, ypos_a;
  logic [23:0] din_a;
  logic        req_b, hs_b, vs_b, de_b, fs_b;
  logic [11:0] xpos_b, ypos_b;
  logic [23:0] din_b;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  always #5 pclk = ~pclk;

  video_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1), .SYNC_POL(1'b1)
  ) dut_a (
    .pclk(pclk), .reset_n(reset_n), .pattern_sel(pattern_sel), .pixel_data(pixel_data),
    .data_req(req_a), .pixel_xpos(xpos_a), .pixel_ypos(ypos_a),
    .video_hsync(hs_a), .video_vsync(vs_a), .video_de(de_a),
    .video_din(din_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1), .SYNC_POL(1'b0)
  ) dut_b (
    .pclk(pclk), .reset_n(reset_n), .pattern_sel(pattern_sel), .pixel_data(pixel_data),
    .data_req(req_b), .pixel_xpos(xpos_b), .pixel_ypos(ypos_b),
    .video_hsync(hs_b), .video_vsync(vs_b), .video_de(de_b),
    .video_din(din_b), .frame_start(fs_b)
  );

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected active pixels of one frame, row-major, for the given mode.
  task automatic push_frame(input logic [1:0] mode);
    logic [23:0] cb [8];
    cb[0] = 24'hFFFFFF; cb[1] = 24'hFFFF00; cb[2] = 24'h00FFFF; cb[3] = 24'h00FF00;
    cb[4] = 24'hFF00FF; cb[5] = 24'hFF0000; cb[6] = 24'h0000FF; cb[7] = 24'h000000;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        case (mode)
          2'b00:   exp_q.push_back({12'h000, 4'(y), 8'(x)});
          2'b01:   exp_q.push_back(cb[x]);
          2'b10:   exp_q.push_back((x == 0 || y == 0) ? 24'hFFFFFF : 24'h000000);
          default: exp_q.push_back(24'hFF0000);
        endcase
      end
    end
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge pclk);
      if (fs_a) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_frame_start: no pulse within %0d cycles", 3 * FRAME);
  endtask

  // Upstream source: answer each request with {ypos,xpos} in the next cycle.
  initial begin
    logic        r;
    logic [11:0] x, y;
    forever begin
      @(negedge pclk);
      r = req_a; x = xpos_a; y = ypos_a;
      @(posedge pclk);
      #1 pixel_data = r ? {12'h000, y[3:0], x[7:0]} : 24'h000000;
    end
  end

  // Monitor: scoreboard on de, raster shape model, de-vs-request lag.
  initial begin
    bit   trk = 0;
    int   c = 0, hist = 0, row, col;
    logic rd1 = 0, rd2 = 0;
    logic [23:0] e;
    logic exp_hs, exp_vs, exp_de;
    forever begin
      @(negedge pclk);
      if (!reset_n) begin
        trk = 0; hist = 0; rd1 = 0; rd2 = 0;
      end else begin
        if (hist >= 2) chk("de_lag", 24'(de_a), 24'(rd2));
        rd2 = rd1; rd1 = req_a;
        if (hist < 2) hist++;
        if (!de_a) chk("din_blank_a", din_a, 24'h0);
        if (!de_b) chk("din_blank_b", din_b, 24'h0);
        if (de_a) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_de", 24'(de_a), 24'h0);
          end else begin
            e = exp_q.pop_front();
            chk("din_a", din_a, e);
            chk("din_b", din_b, e);
          end
        end
        if (!trk && fs_a) begin trk = 1; c = 0; end
        else if (trk) c = (c + 1) % FRAME;
        if (trk) begin
          row = c / H_TOT; col = c % H_TOT;
          exp_hs = (col < 2);
          exp_vs = (row < 1);
          exp_de = (row >= 3) && (row < 7) && (col >= 5) && (col < 13);
          chk("frame_start", 24'(fs_a), 24'(c == 0));
          chk("hsync_a", 24'(hs_a), 24'(exp_hs));
          chk("vsync_a", 24'(vs_a), 24'(exp_vs));
          chk("de_a", 24'(de_a), 24'(exp_de));
          chk("hsync_b", 24'(hs_b), 24'(!exp_hs));
          chk("vsync_b", 24'(vs_b), 24'(!exp_vs));
          chk("de_b", 24'(de_b), 24'(exp_de));
        end
      end
    end
  end

  // Stimulus.
  initial begin
    reset_n = 1'b0; pattern_sel = 2'b00; pixel_data = 24'h0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_req", 24'(req_a), 24'h0);
    chk("rst_xpos", 24'(xpos_a), 24'h0);
    chk("rst_ypos", 24'(ypos_a), 24'h0);
    chk("rst_de", 24'(de_a), 24'h0);
    chk("rst_din", din_a, 24'h0);
    chk("rst_fs", 24'(fs_a), 24'h0);
    chk("rst_hs_a", 24'(hs_a), 24'h0);
    chk("rst_vs_a", 24'(vs_a), 24'h0);
    chk("rst_hs_b", 24'(hs_b), 24'h1);
    chk("rst_vs_b", 24'(vs_b), 24'h1);

    push_frame(2'b00);
    @(negedge pclk); #2 reset_n = 1'b1;

    wait_fs();                                   // frame 0: external
    repeat (60) @(negedge pclk);
    pattern_sel = 2'b01; push_frame(2'b01);
    wait_fs();                                   // frame 1: colour bar
    repeat (60) @(negedge pclk);
    pattern_sel = 2'b11; push_frame(2'b11);      // mid-frame switch
    wait_fs();                                   // frame 2: solid red
    repeat (60) @(negedge pclk);
    pattern_sel = 2'b10; push_frame(2'b10);
    wait_fs();                                   // frame 3: grid
    wait_fs();                                   // frame 4: interrupted by reset
    repeat (49) @(negedge pclk);
    chk("req_before_rst", 24'(req_a), 24'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 24'(req_a), 24'h0);
    chk("mid_rst_xpos", 24'(xpos_a), 24'h0);
    chk("mid_rst_de", 24'(de_a), 24'h0);
    chk("mid_rst_din", din_a, 24'h0);
    chk("mid_rst_fs", 24'(fs_a), 24'h0);
    chk("mid_rst_hs_a", 24'(hs_a), 24'h0);
    chk("mid_rst_vs_a", 24'(vs_a), 24'h0);
    chk("mid_rst_hs_b", 24'(hs_b), 24'h1);
    chk("mid_rst_vs_b", 24'(vs_b), 24'h1);
    chk("mid_rst_q_empty", 24'(exp_q.size()), 24'h0);
    exp_q.delete();
    pattern_sel = 2'b00;
    push_frame(2'b00);
    repeat (3) @(negedge pclk);
    #2 reset_n = 1'b1;
    @(posedge pclk); @(posedge pclk); #1;
    chk("fs_after_2_edges", 24'(fs_a), 24'h0);
    @(posedge pclk); #1;
    chk("fs_after_3_edges", 24'(fs_a), 24'h1);
    repeat (FRAME + 10) @(negedge pclk);
    chk("q_drained", 24'(exp_q.size()), 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
